// File: rtl/sr_reg_bank.sv
// Bank of independent clocked SR storage bits with configurable S=R=1 behaviour,
// a change pulse, sticky per-bit conflict flags and a saturating conflict counter.
module sr_reg_bank #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned CONF_MODE = 0,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             En,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] R,
  input  logic             clr_err,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn,
  output logic             chg,
  output logic [WIDTH-1:0] conflict,
  output logic [CNT_W-1:0] err_cnt
);

  // Unsupported modes collapse to hold
  localparam int unsigned MODE = (CONF_MODE <= 32'd3) ? CONF_MODE : 32'd0;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] conf_hit;
  logic             any_conf;

  // Next stored state per bit
  always_comb begin
    q_nxt    = Q;
    conf_hit = S & R;
    any_conf = 1'b0;
    if (En) begin
      any_conf = |conf_hit;
      for (int i = 0; i < WIDTH; i++) begin
        case ({S[i], R[i]})
          2'b10:   q_nxt[i] = 1'b1;
          2'b01:   q_nxt[i] = 1'b0;
          2'b11: begin
            if (MODE == 32'd1)      q_nxt[i] = 1'b1;
            else if (MODE == 32'd2) q_nxt[i] = 1'b0;
            else if (MODE == 32'd3) q_nxt[i] = ~Q[i];
            else                    q_nxt[i] = Q[i];
          end
          default: q_nxt[i] = Q[i];
        endcase
      end
    end
  end

  // Storage and change pulse; clr_err never touches these
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Q   <= '0;
      chg <= 1'b0;
    end else begin
      Q   <= q_nxt;
      chg <= (q_nxt != Q);
    end
  end

  // Conflict bookkeeping; a clear in the same cycle discards new conflicts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict <= '0;
      err_cnt  <= '0;
    end else if (clr_err) begin
      conflict <= '0;
      err_cnt  <= '0;
    end else if (En) begin
      conflict <= conflict | conf_hit;
      if (any_conf && (err_cnt != CNT_MAX)) err_cnt <= err_cnt + CNT_W'(1);
    end
  end

  assign Qn = ~Q;

endmodule

// File: tb/tb_sr_reg_bank.sv
// Directed and randomised checks of sr_reg_bank across all conflict modes,
// an out-of-range mode and a narrow saturating counter.
module tb_sr_reg_bank;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [3:0] s = 4'h0;
  logic [3:0] r = 4'h0;
  logic       clr = 1'b0;

  // Index 0..3 = CONF_MODE 0..3 (CNT_W=8); index 4 = CONF_MODE 5 with CNT_W=2
  logic [3:0] q  [5];
  logic [3:0] qn [5];
  logic [3:0] cf [5];
  logic       chg[5];
  logic [7:0] ec [4];
  logic [1:0] ec_c;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar m = 0; m < 4; m++) begin : g_mode
    sr_reg_bank #(.WIDTH(4), .CONF_MODE(m), .CNT_W(8)) u_dut (
      .clk(clk), .rst(rst), .En(en), .S(s), .R(r), .clr_err(clr),
      .Q(q[m]), .Qn(qn[m]), .chg(chg[m]), .conflict(cf[m]), .err_cnt(ec[m])
    );
  end

  sr_reg_bank #(.WIDTH(4), .CONF_MODE(5), .CNT_W(2)) u_dut_c (
    .clk(clk), .rst(rst), .En(en), .S(s), .R(r), .clr_err(clr),
    .Q(q[4]), .Qn(qn[4]), .chg(chg[4]), .conflict(cf[4]), .err_cnt(ec_c)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    for (int k = 0; k < 5; k++) begin
      total++;
      if (q[k] !== 4'h0 || qn[k] !== 4'hf || chg[k] !== 1'b0 || cf[k] !== 4'h0) begin
        bad++;
        $display("FAIL reset_state[%0d] got q=%h qn=%h chg=%b cf=%h want q=0 qn=f chg=0 cf=0",
                 k, q[k], qn[k], chg[k], cf[k]);
      end
    end
    total++;
    if (ec[0] !== 8'd0 || ec_c !== 2'd0) begin
      bad++;
      $display("FAIL reset_cnt got %0d/%0d want 0/0", ec[0], ec_c);
    end
    // inputs ignored while reset is held across an edge
    en = 1'b1; s = 4'hf; r = 4'h0;
    step();
    total++;
    if (q[0] !== 4'h0 || chg[0] !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold got q=%h chg=%b want q=0 chg=0", q[0], chg[0]);
    end
    rst = 1'b0; en = 1'b0; s = 4'h0;
  endtask

  task automatic test_set();
    en = 1'b1; s = 4'hf; r = 4'h0;
    step();
    for (int k = 0; k < 5; k++) begin
      total++;
      if (q[k] !== 4'hf || qn[k] !== 4'h0 || chg[k] !== 1'b1) begin
        bad++;
        $display("FAIL set[%0d] got q=%h qn=%h chg=%b want q=f qn=0 chg=1", k, q[k], qn[k], chg[k]);
      end
    end
  endtask

  task automatic test_conflict();
    logic [3:0] exp_q  [5];
    logic       exp_ch [5];
    exp_q  = '{4'hf, 4'hf, 4'h0, 4'h0, 4'hf};
    exp_ch = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    s = 4'hf; r = 4'hf;
    step();
    for (int k = 0; k < 5; k++) begin
      total++;
      if (q[k] !== exp_q[k] || chg[k] !== exp_ch[k] || cf[k] !== 4'hf) begin
        bad++;
        $display("FAIL conflict[%0d] got q=%h chg=%b cf=%h want q=%h chg=%b cf=f",
                 k, q[k], chg[k], cf[k], exp_q[k], exp_ch[k]);
      end
    end
    total++;
    if (ec[0] !== 8'd1 || ec[3] !== 8'd1 || ec_c !== 2'd1) begin
      bad++;
      $display("FAIL conflict_cnt got %0d/%0d/%0d want 1/1/1", ec[0], ec[3], ec_c);
    end
  endtask

  task automatic test_enable_hold();
    logic [3:0] exp_q  [5];
    logic       exp_ch [5];
    exp_q  = '{4'hf, 4'hf, 4'h0, 4'h0, 4'hf};
    en = 1'b0; s = 4'h0; r = 4'hf;
    for (int n = 0; n < 3; n++) begin
      step();
      for (int k = 0; k < 5; k++) begin
        total++;
        if (q[k] !== exp_q[k] || chg[k] !== 1'b0) begin
          bad++;
          $display("FAIL en_hold[%0d] edge %0d got q=%h chg=%b want q=%h chg=0", k, n, q[k], chg[k], exp_q[k]);
        end
      end
      total++;
      if (ec[0] !== 8'd1 || cf[0] !== 4'hf) begin
        bad++;
        $display("FAIL en_hold_err got cnt=%0d cf=%h want cnt=1 cf=f", ec[0], cf[0]);
      end
    end
    en = 1'b1;
    step();
    exp_ch = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 5; k++) begin
      total++;
      if (q[k] !== 4'h0 || qn[k] !== 4'hf || chg[k] !== exp_ch[k]) begin
        bad++;
        $display("FAIL en_resume[%0d] got q=%h qn=%h chg=%b want q=0 qn=f chg=%b",
                 k, q[k], qn[k], chg[k], exp_ch[k]);
      end
    end
  endtask

  task automatic test_saturate();
    logic [1:0] exp_c [6];
    exp_c = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
    clr = 1'b1; en = 1'b1; s = 4'h0; r = 4'h0;
    step();
    total++;
    if (ec[0] !== 8'd0 || ec_c !== 2'd0 || cf[0] !== 4'h0 || q[0] !== 4'h0 || chg[0] !== 1'b0) begin
      bad++;
      $display("FAIL clr got cnt=%0d/%0d cf=%h q=%h chg=%b want 0/0 cf=0 q=0 chg=0",
               ec[0], ec_c, cf[0], q[0], chg[0]);
    end
    clr = 1'b0; s = 4'h1; r = 4'h1;
    for (int n = 0; n < 6; n++) begin
      step();
      total++;
      if (ec_c !== exp_c[n] || ec[0] !== 8'(n + 1)) begin
        bad++;
        $display("FAIL sat_cnt edge %0d got %0d/%0d want %0d/%0d", n, ec_c, ec[0], exp_c[n], n + 1);
      end
    end
    clr = 1'b1;
    step();
    total++;
    if (ec_c !== 2'd0 || cf[4] !== 4'h0 || ec[0] !== 8'd0 || cf[0] !== 4'h0) begin
      bad++;
      $display("FAIL clr_wins got cnt=%0d/%0d cf=%h/%h want 0/0 cf=0/0", ec_c, ec[0], cf[4], cf[0]);
    end
    clr = 1'b0;
  endtask

  task automatic test_async_reset();
    s = 4'h4; r = 4'h4;
    step();
    s = 4'ha; r = 4'h5;
    step();
    total++;
    if (q[0] !== 4'ha || ec[0] !== 8'd1 || chg[0] !== 1'b1) begin
      bad++;
      $display("FAIL pre_rst got q=%h cnt=%0d chg=%b want q=a cnt=1 chg=1", q[0], ec[0], chg[0]);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (q[0] !== 4'h0 || qn[0] !== 4'hf || ec[0] !== 8'd0 || chg[0] !== 1'b0 || cf[0] !== 4'h0) begin
      bad++;
      $display("FAIL async_rst got q=%h qn=%h cnt=%0d chg=%b cf=%h want q=0 qn=f cnt=0 chg=0 cf=0",
               q[0], qn[0], ec[0], chg[0], cf[0]);
    end
    s = 4'hf; r = 4'h0;
    step();
    total++;
    if (q[0] !== 4'h0 || chg[0] !== 1'b0) begin
      bad++;
      $display("FAIL rst_held got q=%h chg=%b want q=0 chg=0", q[0], chg[0]);
    end
    rst = 1'b0; s = 4'h0;
    step();
    total++;
    if (q[0] !== 4'h0 || chg[0] !== 1'b0 || ec[0] !== 8'd0) begin
      bad++;
      $display("FAIL post_rst got q=%h chg=%b cnt=%0d want q=0 chg=0 cnt=0", q[0], chg[0], ec[0]);
    end
  endtask

  function automatic logic [3:0] model_q(int mode, logic [3:0] cur, logic e, logic [3:0] sv, logic [3:0] rv);
    logic [3:0] res;
    res = cur;
    if (e) begin
      res = (cur | sv) & ~rv;
      for (int i = 0; i < 4; i++) begin
        if (sv[i] && rv[i]) begin
          if (mode == 1)      res[i] = 1'b1;
          else if (mode == 2) res[i] = 1'b0;
          else if (mode == 3) res[i] = ~cur[i];
          else                res[i] = cur[i];
        end
      end
    end
    return res;
  endfunction

  task automatic test_random();
    logic [3:0] mq  [5];
    logic [3:0] mcf [5];
    logic       mch [5];
    int         mcnt[5];
    int         mode, cmax;
    logic [3:0] nq;
    // start from a known state via an async reset between edges
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      mq[k] = 4'h0; mcf[k] = 4'h0; mch[k] = 1'b0; mcnt[k] = 0;
    end
    for (int n = 0; n < 1000; n++) begin
      s   = 4'($urandom);
      r   = 4'($urandom);
      en  = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 19) == 0);
      for (int k = 0; k < 5; k++) begin
        mode = (k == 4) ? 0 : k;
        cmax = (k == 4) ? 3 : 255;
        nq = model_q(mode, mq[k], en, s, r);
        mch[k] = (nq != mq[k]);
        mq[k] = nq;
        if (clr) begin
          mcf[k] = 4'h0; mcnt[k] = 0;
        end else if (en) begin
          mcf[k] = mcf[k] | (s & r);
          if ((s & r) != 4'h0 && mcnt[k] < cmax) mcnt[k]++;
        end
      end
      step();
      for (int k = 0; k < 5; k++) begin
        total++;
        if (q[k] !== mq[k] || qn[k] !== ~mq[k] || chg[k] !== mch[k] || cf[k] !== mcf[k]) begin
          bad++;
          $display("FAIL rand[%0d] cyc %0d got q=%h qn=%h chg=%b cf=%h want q=%h qn=%h chg=%b cf=%h",
                   k, n, q[k], qn[k], chg[k], cf[k], mq[k], ~mq[k], mch[k], mcf[k]);
        end
      end
      for (int k = 0; k < 4; k++) begin
        total++;
        if (ec[k] !== 8'(mcnt[k])) begin
          bad++;
          $display("FAIL rand_cnt[%0d] cyc %0d got %0d want %0d", k, n, ec[k], mcnt[k]);
        end
      end
      total++;
      if (ec_c !== 2'(mcnt[4])) begin
        bad++;
        $display("FAIL rand_cnt_c cyc %0d got %0d want %0d", n, ec_c, mcnt[4]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_set();
    test_conflict();
    test_enable_hold();
    test_saturate();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
